// File: rtl/nrf_spi_responder.sv
// nRF24L01 SPI responder: emulates the radio's command/register set
// and exposes RX injection and TX drain handshakes to local logic.
module nrf_spi_responder #(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         nrf_ce,
  input  logic                         nrf_csn,
  input  logic                         nrf_sck,
  input  logic                         nrf_mosi,
  output logic                         nrf_miso,
  output logic                         nrf_irq,
  input  logic                         rx_load_valid,
  output logic                         rx_load_ready,
  input  logic [8*PAYLOAD_BYTES-1:0]   rx_load_data,
  output logic                         tx_out_valid,
  input  logic                         tx_out_ready,
  output logic [8*PAYLOAD_BYTES-1:0]   tx_out_data
);

  localparam int PW = PAYLOAD_BYTES;
  localparam int W  = 8 * PAYLOAD_BYTES;
  localparam logic [63:0] RF_RST = 64'h00_0F_02_03_03_03_3F_08;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      state_q, state_d;
  logic [2:0]  csn_q, sck_q;
  logic [1:0]  mosi_q;
  logic [2:0]  bit_cnt;
  logic [5:0]  dcnt;
  logic [6:0]  sin_q;
  logic [7:0]  sout_q, cmd_q;
  logic [7:0]  rf [0:7];
  logic [W-1:0] rx_buf, tx_stage, tx_data;
  logic        rx_full, tx_full, rx_dr, tx_ds, tx_ok, irq_q;

  logic       csn_s, csn_fall, csn_rise, sck_rise, sck_fall;
  logic       byte_done, in_data, end_ok;
  logic [7:0] byte_in, status, reg_rd, rx_byte, next_byte;
  logic       is_rreg, is_wreg, is_rrx, is_wtx;
  logic       wr_fire, tx_cap, rx_rel, tx_commit, tx_flush;
  logic       rx_acc, tx_hs;
  logic [1:0] st_clr;

  assign csn_s    = csn_q[1];
  assign csn_fall = csn_q[2] & ~csn_q[1];
  assign csn_rise = ~csn_q[2] & csn_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign byte_in  = {sin_q, mosi_q[1]};

  assign in_data   = state_q == DATA;
  assign byte_done = sck_rise & ~csn_s
                   & (state_q != IDLE) & (bit_cnt == 3'd7);

  assign is_rreg = cmd_q[7:5] == 3'b000;
  assign is_wreg = cmd_q[7:5] == 3'b001;
  assign is_rrx  = cmd_q == 8'h61;
  assign is_wtx  = cmd_q == 8'hA0;

  assign status = {1'b0, rx_dr, tx_ds, 1'b0,
                   {3{~rx_full}}, tx_full};

  assign end_ok    = csn_rise & in_data;
  assign wr_fire   = byte_done & in_data & is_wreg
                   & (dcnt == 6'd0);
  assign tx_cap    = byte_done & in_data & is_wtx & tx_ok;
  assign rx_rel    = end_ok & ((is_rrx & (dcnt >= 6'(PW)))
                   | (cmd_q == 8'hE2));
  assign tx_commit = end_ok & is_wtx & tx_ok & ~tx_full
                   & (dcnt >= 6'(PW));
  assign tx_flush  = end_ok & (cmd_q == 8'hE1);
  assign rx_acc    = rx_load_valid & ~rx_full;
  assign tx_hs     = tx_out_valid & tx_out_ready;
  assign st_clr    = (wr_fire && cmd_q[4:0] == 5'd7)
                   ? byte_in[6:5] : 2'b00;

  assign nrf_miso      = (state_q != IDLE) & sout_q[7];
  assign nrf_irq       = irq_q;
  assign rx_load_ready = ~rx_full;
  assign tx_out_valid  = tx_full & nrf_ce;
  assign tx_out_data   = tx_data;

  always_comb begin
    reg_rd = 8'h00;
    if (cmd_q[4:3] == 2'b00)
      reg_rd = (cmd_q[2:0] == 3'd7) ? status : rf[cmd_q[2:0]];
    rx_byte = 8'h00;
    for (int i = 0; i < PW; i++)
      if (dcnt == 6'(i)) rx_byte = rx_buf[8*i +: 8];
    next_byte = 8'h00;
    unique case (1'b1)
      is_rreg: next_byte = reg_rd;
      is_rrx:  next_byte = rx_byte;
      default: next_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (csn_fall) state_d = CMD;
      CMD:     if (byte_done) state_d = DATA;
      DATA:    state_d = DATA;
      default: state_d = IDLE;
    endcase
    if (csn_s) state_d = IDLE;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      csn_q   <= 3'b111;
      sck_q   <= 3'b000;
      mosi_q  <= 2'b00;
      state_q <= IDLE;
    end else begin
      csn_q   <= {csn_q[1:0], nrf_csn};
      sck_q   <= {sck_q[1:0], nrf_sck};
      mosi_q  <= {mosi_q[0], nrf_mosi};
      state_q <= state_d;
    end
  end

  // Shift engine: in on detected rise, out on detected fall
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bit_cnt <= '0;
      dcnt    <= '0;
      sin_q   <= '0;
      sout_q  <= '0;
      cmd_q   <= '0;
      tx_ok   <= 1'b0;
    end else if (csn_fall) begin
      bit_cnt <= '0;
      dcnt    <= '0;
      sout_q  <= status;
    end else if (state_q != IDLE && !csn_s) begin
      if (sck_rise) begin
        sin_q   <= byte_in[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          if (state_q == CMD) begin
            cmd_q <= byte_in;
            tx_ok <= ~tx_full;
            dcnt  <= '0;
          end else if (dcnt != 6'h3F) begin
            dcnt <= dcnt + 6'd1;
          end
        end
      end
      if (sck_fall) begin
        if (bit_cnt == 3'd0 && in_data) sout_q <= next_byte;
        else sout_q <= {sout_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= RF_RST[8*i +: 8];
      rx_buf   <= '0;
      tx_stage <= '0;
      tx_data  <= '0;
      rx_full  <= 1'b0;
      tx_full  <= 1'b0;
      rx_dr    <= 1'b0;
      tx_ds    <= 1'b0;
      irq_q    <= 1'b1;
    end else begin
      if (wr_fire && cmd_q[4:3] == 2'b00 && cmd_q[2:0] != 3'd7)
        rf[cmd_q[2:0]] <= byte_in;
      for (int i = 0; i < PW; i++)
        if (tx_cap && dcnt == 6'(i)) tx_stage[8*i +: 8] <= byte_in;
      if (tx_commit) tx_data <= tx_stage;
      if (rx_acc) rx_buf <= rx_load_data;
      // A release and a load in one cycle leave the buffer full
      if (rx_acc) rx_full <= 1'b1;
      else if (rx_rel) rx_full <= 1'b0;
      if (tx_commit) tx_full <= 1'b1;
      else if (tx_hs || tx_flush) tx_full <= 1'b0;
      rx_dr <= (rx_dr & ~st_clr[1]) | rx_acc;
      tx_ds <= (tx_ds & ~st_clr[0]) | tx_hs;
      irq_q <= ~((rx_dr & ~rf[0][6]) | (tx_ds & ~rf[0][5]));
    end
  end

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Directed bench for nrf_spi_responder: register table plus
// hand-written RX, TX, flush and reset sequences.
module tb_nrf_spi_responder;

  logic        clk = 0, rst_n = 0, ce = 0, csn = 1, sck = 0, mosi = 0;
  logic        miso, irq, rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;
  logic [31:0] rx_data = '0, tx_data;
  logic [39:0] mi;
  int          checks = 0, errors = 0;

  typedef struct {
    int          nbits;
    logic [39:0] mo;
    logic [39:0] ex;
    int          nb;
  } vec_t;
  vec_t vt[13];

  nrf_spi_responder #(.PAYLOAD_BYTES(4)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .nrf_ce(ce),
    .nrf_csn(csn), .nrf_sck(sck), .nrf_mosi(mosi),
    .nrf_miso(miso), .nrf_irq(irq),
    .rx_load_valid(rx_valid), .rx_load_ready(rx_ready),
    .rx_load_data(rx_data),
    .tx_out_valid(tx_valid), .tx_out_ready(tx_ready),
    .tx_out_data(tx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input int nbits, input logic [39:0] mo,
                      input bit hold);
    mi = '0;
    csn = 0;
    clks(6);
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[39-k];
      clks(6);
      mi[39-k] = miso;
      sck = 1;
      clks(6);
      sck = 0;
    end
    clks(6);
    if (!hold) begin
      csn = 1;
      clks(8);
    end
  endtask

  task automatic run(input string nm, input int nbits,
                     input logic [39:0] mo, input logic [39:0] ex,
                     input int nb);
    xfer(nbits, mo, 1'b0);
    for (int b = 0; b < nb; b++)
      chk($sformatf("%s byte%0d", nm, b),
          40'(mi[39-8*b -: 8]), 40'(ex[39-8*b -: 8]));
  endtask

  task automatic nop(input string nm, input logic [7:0] st);
    run(nm, 8, 40'hFF00000000, {st, 32'h0}, 1);
  endtask

  task automatic pulse_ready();
    tx_ready = 1;
    clks(1);
    tx_ready = 0;
    clks(3);
  endtask

  initial begin
    vt[0]  = '{8,  40'hFF00000000, 40'h0E00000000, 1};
    vt[1]  = '{24, 40'h00FFFF0000, 40'h0E08080000, 3};
    vt[2]  = '{16, 40'h01FF000000, 40'h0E3F000000, 2};
    vt[3]  = '{16, 40'h02FF000000, 40'h0E03000000, 2};
    vt[4]  = '{16, 40'h04FF000000, 40'h0E03000000, 2};
    vt[5]  = '{16, 40'h06FF000000, 40'h0E0F000000, 2};
    vt[6]  = '{16, 40'h07FF000000, 40'h0E0E000000, 2};
    vt[7]  = '{16, 40'h254C000000, 40'h0E00000000, 2};
    vt[8]  = '{16, 40'h05FF000000, 40'h0E4C000000, 2};
    vt[9]  = '{13, 40'h2570000000, 40'h0E00000000, 1};
    vt[10] = '{16, 40'h05FF000000, 40'h0E4C000000, 2};
    vt[11] = '{16, 40'h2A55000000, 40'h0E00000000, 2};
    vt[12] = '{16, 40'h0AFF000000, 40'h0E00000000, 2};

    clks(4);
    chk("rst miso", 40'(miso), 40'd0);
    chk("rst irq", 40'(irq), 40'd1);
    chk("rst rx_ready", 40'(rx_ready), 40'd1);
    chk("rst tx_valid", 40'(tx_valid), 40'd0);
    chk("rst tx_data", 40'(tx_data), 40'd0);
    rst_n = 1;
    clks(4);

    for (int i = 0; i < 13; i++)
      run($sformatf("vec%0d", i), vt[i].nbits, vt[i].mo,
          vt[i].ex, vt[i].nb);
    chk("reg irq", 40'(irq), 40'd1);

    // RX injection and readout
    rx_data = 32'hDEADBEEF;
    rx_valid = 1;
    clks(1);
    rx_valid = 0;
    clks(3);
    chk("rx ready low", 40'(rx_ready), 40'd0);
    chk("rx irq low", 40'(irq), 40'd0);
    nop("rx status", 8'h40);
    run("rx read", 40, 40'h61FFFFFFFF, 40'h40EFBEADDE, 5);
    chk("rx released", 40'(rx_ready), 40'd1);
    run("rx w1c", 16, 40'h2740000000, 40'h4E00000000, 1);
    chk("rx irq high", 40'(irq), 40'd1);
    nop("rx clr status", 8'h0E);

    // TX commit and drain
    ce = 1;
    run("tx write", 40, 40'hA011223344, 40'h0E00000000, 1);
    chk("tx valid", 40'(tx_valid), 40'd1);
    chk("tx data", 40'(tx_data), 40'h44332211);
    ce = 0;
    clks(1);
    chk("tx ce gate", 40'(tx_valid), 40'd0);
    ce = 1;
    nop("tx full status", 8'h0F);
    pulse_ready();
    chk("tx drained", 40'(tx_valid), 40'd0);
    chk("tx irq low", 40'(irq), 40'd0);
    nop("tx ds status", 8'h2E);
    run("tx w1c", 16, 40'h2720000000, 40'h2E00000000, 1);
    run("cfg mask", 16, 40'h2028000000, 40'h0E00000000, 1);
    run("tx write2", 40, 40'hA0AABBCCDD, 40'h0E00000000, 1);
    chk("tx data2", 40'(tx_data), 40'hDDCCBBAA);
    pulse_ready();
    chk("tx masked irq", 40'(irq), 40'd1);
    nop("tx ds status2", 8'h2E);
    run("tx w1c2", 16, 40'h2720000000, 40'h2E00000000, 1);
    run("cfg restore", 16, 40'h2008000000, 40'h0E00000000, 1);
    run("tx short", 32, 40'hA011223300, 40'h0E00000000, 1);
    chk("tx short valid", 40'(tx_valid), 40'd0);
    chk("tx short data", 40'(tx_data), 40'hDDCCBBAA);

    // FLUSH_RX release coinciding with a load
    xfer(8, 40'hE200000000, 1'b1);
    csn = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rx_data = 32'h01020304;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    clks(6);
    chk("flush+load full", 40'(rx_ready), 40'd0);
    nop("flush status", 8'h40);
    chk("flush irq", 40'(irq), 40'd0);

    // Reset in the middle of a byte
    csn = 0;
    clks(6);
    for (int k = 0; k < 3; k++) begin
      mosi = 1;
      sck = 1;
      clks(6);
      sck = 0;
      clks(6);
    end
    rst_n = 0;
    #2;
    chk("mid rst miso", 40'(miso), 40'd0);
    chk("mid rst irq", 40'(irq), 40'd1);
    chk("mid rst rx_ready", 40'(rx_ready), 40'd1);
    chk("mid rst tx_valid", 40'(tx_valid), 40'd0);
    chk("mid rst tx_data", 40'(tx_data), 40'd0);
    csn = 1;
    mosi = 0;
    clks(3);
    rst_n = 1;
    clks(4);
    nop("post rst status", 8'h0E);
    run("post rst rf_ch", 16, 40'h05FF000000, 40'h0E02000000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
